hack_data_mem: RTL and testbench
================================

# hack_data_mem

Data-memory responder for the Hack CPU data port: it services the CPU's address/write-enable/write-data outputs and returns read data in the same cycle. It decodes the 15-bit address into RAM (16K words), screen memory (8K words) and the keyboard register. Screen writes are mirrored onto a buffered valid/ready stream toward the display controller. Keystrokes arrive on a valid/ready stream and are queued in a FIFO that the CPU reads and pops through the keyboard address.

## Interface
- KBD_DEPTH, 8: keyboard FIFO depth in entries; power of two, ≥2.
- SCR_DEPTH, 4: screen-update FIFO depth in entries; power of two, ≥2.

- clk_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- addr_i  in  15  word address from CPU (CPU dmem address).
- wr_en_i  in  1  write strobe from CPU.
- wdata_i  in  16  write data from CPU.
- rdata_o  out  16  read data to CPU; combinational from addr_i.
- scr_valid_o  out  1  screen-update entry available.
- scr_addr_o  out  13  screen word offset (addr_i − 0x4000) of head entry.
- scr_data_o  out  16  pixel word of head entry.
- scr_ready_i  in  1  display controller accepts head entry.
- scr_ovf_o  out  1  sticky: a screen update was dropped.
- kbd_valid_i  in  1  keystroke offered.
- kbd_code_i  in  16  keystroke code; 0 is never pushed by the source.
- kbd_ready_o  out  1  keyboard FIFO can accept.
- kbd_count_o  out  $clog2(KBD_DEPTH)+1  keyboard FIFO occupancy.

## Operation
- Address map: 0x0000–0x3FFF RAM; 0x4000–0x5FFF screen; 0x6000 KBD; 0x6001–0x7FFF unmapped.
- Reads are asynchronous: RAM/screen return the array word; KBD returns the FIFO head code, or 0x0000 when empty; unmapped returns 0x0000.
- Writes occur on the clock edge when wr_en_i=1. RAM: store. Screen: store into the local shadow array and push {offset, wdata_i} into the screen FIFO. KBD: any data value pops the head; a pop on an empty FIFO is ignored and the write value is discarded. Unmapped: ignored.
- RAM and screen arrays are not reset; their contents are undefined until written.
- Screen FIFO: scr_valid_o = not empty; the head is presented on scr_addr_o/scr_data_o; it pops when scr_valid_o & scr_ready_i.
  - Push when full with simultaneous pop: accepted, occupancy unchanged.
  - Push when full without pop: the entry is dropped and scr_ovf_o is set. The shadow array is still written.
  - scr_ovf_o clears only on reset.
- Keyboard FIFO: kbd_ready_o = not full; it pushes when kbd_valid_i & kbd_ready_o.
  - Push and CPU pop in the same cycle: both happen, count unchanged.
  - If the FIFO is empty, the new head is the pushed code.
- Pointers wrap modulo depth. Occupancy is held in a separate counter so that full and empty are distinguishable.

## Timing
- Reset (async assert) returns:
  - both FIFOs to empty; scr_valid_o=0, scr_ovf_o=0, kbd_ready_o=1, kbd_count_o=0;
  - KBD read to 0x0000.
- Reset mid-stream discards all queued entries. An in-flight screen handshake is abandoned.
- Read latency is 0 cycles (combinational). A write is visible to reads from the cycle after its edge; there is no same-cycle bypass.
- Screen path: a CPU screen write at edge N gives scr_valid_o=1 from N+1. It pops at the first edge with scr_ready_i=1, so minimum residency is 1 cycle.
- Keyboard path: a keystroke accepted at edge N is readable at KBD from N+1 if the FIFO was empty.
- A CPU pop at edge M exposes the next code, or 0, from M+1.
- scr_valid_o, scr_addr_o, scr_data_o, kbd_ready_o and kbd_count_o are registered or derived only from registered state. None depend combinationally on the ready/valid inputs.

## Test plan
- Reset, then write 0x1234 to RAM 0x0005 and 0xBEEF to RAM 0x3FFF; read both back → 0x1234 and 0xBEEF. Read 0x7000 → 0x0000.
- With scr_ready_i=0, write 5 screen words at 0x4000..0x4004 (SCR_DEPTH=4) → scr_valid_o=1 and head {0x0000, first data}. scr_ovf_o=1 after the 5th write. All 5 words read back from the shadow.
- Screen FIFO full, then write to 0x4010 in the same cycle that scr_ready_i=1 → no overflow, occupancy stays 4, and the drained order matches write order.
- Push codes 0x41, 0x42, 0x43; read KBD → 0x41. Write KBD → next read 0x42. Two more pops → reads 0x43 then 0x0000. A further pop on empty → still 0x0000, no underflow.
- Fill the keyboard FIFO to 8 → kbd_ready_o=0 and the 9th code is not accepted. A CPU pop with kbd_valid_i held → kbd_ready_o=1 next cycle and the 9th code is accepted on the following edge.
- Assert reset_i asynchronously between edges with both FIFOs non-empty → outputs go immediately to scr_valid_o=0, kbd_count_o=0, kbd_ready_o=1 and KBD read 0x0000.

Source files
------------

// File: rtl/hack_data_mem_if.sv
// Hack CPU data-port bus plus the screen-update and keystroke streams.
// KBD_DEPTH must match the responder's parameter; it sizes the occupancy field.
interface hack_data_mem_if #(parameter int KBD_DEPTH = 8);
  logic [14:0]                  addr_i;
  logic                         wr_en_i;
  logic [15:0]                  wdata_i;
  logic [15:0]                  rdata_o;
  logic                         scr_valid_o;
  logic [12:0]                  scr_addr_o;
  logic [15:0]                  scr_data_o;
  logic                         scr_ready_i;
  logic                         scr_ovf_o;
  logic                         kbd_valid_i;
  logic [15:0]                  kbd_code_i;
  logic                         kbd_ready_o;
  logic [$clog2(KBD_DEPTH):0]   kbd_count_o;

  modport slave (
    input  addr_i, wr_en_i, wdata_i, scr_ready_i, kbd_valid_i, kbd_code_i,
    output rdata_o, scr_valid_o, scr_addr_o, scr_data_o, scr_ovf_o,
           kbd_ready_o, kbd_count_o
  );

  modport master (
    output addr_i, wr_en_i, wdata_i, scr_ready_i, kbd_valid_i, kbd_code_i,
    input  rdata_o, scr_valid_o, scr_addr_o, scr_data_o, scr_ovf_o,
           kbd_ready_o, kbd_count_o
  );
endinterface

// File: rtl/hack_data_mem.sv
// Hack data memory: 16K RAM, 8K screen shadow with an update stream out,
// and a keyboard FIFO popped by CPU writes to the KBD address.
module hack_data_mem #(
  parameter int KBD_DEPTH = 8,
  parameter int SCR_DEPTH = 4
) (
  input logic            clk_i,
  input logic            reset_i,
  hack_data_mem_if.slave bus
);
  localparam int KW = $clog2(KBD_DEPTH);
  localparam int SW = $clog2(SCR_DEPTH);
  localparam logic [KW:0] KBD_FULL = KBD_DEPTH[KW:0];
  localparam logic [SW:0] SCR_FULL = SCR_DEPTH[SW:0];

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_entry_t;

  logic [15:0] ram    [0:16383];
  logic [15:0] screen [0:8191];
  scr_entry_t  scr_mem [0:SCR_DEPTH-1];
  logic [15:0] kbd_mem [0:KBD_DEPTH-1];

  logic [SW-1:0] scr_wr, scr_rd;
  logic [SW:0]   scr_cnt;
  logic          scr_ovf;
  logic [KW-1:0] kbd_wr, kbd_rd;
  logic [KW:0]   kbd_cnt;

  logic is_ram, is_scr, is_kbd;
  assign is_ram = ~bus.addr_i[14];
  assign is_scr = (bus.addr_i[14:13] == 2'b10);
  assign is_kbd = (bus.addr_i == 15'h6000);

  logic scr_req, scr_pop, scr_push, scr_drop, scr_full;
  logic kbd_push, kbd_pop, kbd_empty;
  assign scr_full  = (scr_cnt == SCR_FULL);
  assign scr_req   = bus.wr_en_i & is_scr;
  assign scr_pop   = bus.scr_valid_o & bus.scr_ready_i;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign scr_push  = scr_req & (~scr_full | scr_pop);
  assign scr_drop  = scr_req & scr_full & ~scr_pop;
  assign kbd_empty = (kbd_cnt == '0);
  assign kbd_push  = bus.kbd_valid_i & bus.kbd_ready_o;
  assign kbd_pop   = bus.wr_en_i & is_kbd & ~kbd_empty;

  scr_entry_t head;
  assign head            = scr_mem[scr_rd];
  assign bus.scr_valid_o = (scr_cnt != '0);
  assign bus.scr_addr_o  = head.addr;
  assign bus.scr_data_o  = head.data;
  assign bus.scr_ovf_o   = scr_ovf;
  assign bus.kbd_ready_o = (kbd_cnt != KBD_FULL);
  assign bus.kbd_count_o = kbd_cnt;

  always_comb begin
    bus.rdata_o = 16'h0000;
    if (is_ram)                       bus.rdata_o = ram[bus.addr_i[13:0]];
    else if (is_scr)                  bus.rdata_o = screen[bus.addr_i[12:0]];
    else if (is_kbd && !kbd_empty)    bus.rdata_o = kbd_mem[kbd_rd];
  end

  // Storage arrays carry no reset; only FIFO control state does.
  always_ff @(posedge clk_i) begin
    if (bus.wr_en_i && is_ram) ram[bus.addr_i[13:0]] <= bus.wdata_i;
    if (scr_req)               screen[bus.addr_i[12:0]] <= bus.wdata_i;
    if (scr_push)              scr_mem[scr_wr] <= '{addr: bus.addr_i[12:0], data: bus.wdata_i};
    if (kbd_push)              kbd_mem[kbd_wr] <= bus.kbd_code_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      scr_wr  <= '0;
      scr_rd  <= '0;
      scr_cnt <= '0;
      scr_ovf <= 1'b0;
      kbd_wr  <= '0;
      kbd_rd  <= '0;
      kbd_cnt <= '0;
    end else begin
      if (scr_push) scr_wr <= scr_wr + 1'b1;
      if (scr_pop)  scr_rd <= scr_rd + 1'b1;
      case ({scr_push, scr_pop})
        2'b10:   scr_cnt <= scr_cnt + 1'b1;
        2'b01:   scr_cnt <= scr_cnt - 1'b1;
        default: scr_cnt <= scr_cnt;
      endcase
      if (scr_drop) scr_ovf <= 1'b1;

      if (kbd_push) kbd_wr <= kbd_wr + 1'b1;
      if (kbd_pop)  kbd_rd <= kbd_rd + 1'b1;
      case ({kbd_push, kbd_pop})
        2'b10:   kbd_cnt <= kbd_cnt + 1'b1;
        2'b01:   kbd_cnt <= kbd_cnt - 1'b1;
        default: kbd_cnt <= kbd_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: RAM/screen/KBD decode, screen stream
// overflow and drain order, keyboard FIFO fill/pop, async reset.
module tb_hack_data_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  hack_data_mem_if #(.KBD_DEPTH(8)) bus ();

  hack_data_mem #(.KBD_DEPTH(8), .SCR_DEPTH(4)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.wr_en_i = 1'b1;
    tick();
    bus.wr_en_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    bus.addr_i = a;
    #1;
    chk(tag, {16'h0, bus.rdata_o}, {16'h0, exp});
  endtask

  initial begin
    bus.addr_i      = '0;
    bus.wr_en_i     = 1'b0;
    bus.wdata_i     = '0;
    bus.scr_ready_i = 1'b0;
    bus.kbd_valid_i = 1'b0;
    bus.kbd_code_i  = '0;
    #12 rst = 1'b0;
    #1;
    chk("rst_scr_valid", {31'h0, bus.scr_valid_o}, 32'd0);
    chk("rst_scr_ovf",   {31'h0, bus.scr_ovf_o},   32'd0);
    chk("rst_kbd_ready", {31'h0, bus.kbd_ready_o}, 32'd1);
    chk("rst_kbd_count", {28'h0, bus.kbd_count_o}, 32'd0);
    rd("rst_kbd_read", 15'h6000, 16'h0000);

    // RAM and unmapped
    @(negedge clk);
    wr(15'h0005, 16'h1234);
    wr(15'h3FFF, 16'hBEEF);
    rd("ram_0005", 15'h0005, 16'h1234);
    rd("ram_3fff", 15'h3FFF, 16'hBEEF);
    rd("unmapped_7000", 15'h7000, 16'h0000);

    // Screen overflow with display stalled
    for (int i = 0; i < 5; i++) begin
      wr(15'h4000 + 15'(i), 16'hA000 + 16'(i));
      if (i == 3) chk("scr_ovf_at_4", {31'h0, bus.scr_ovf_o}, 32'd0);
    end
    chk("scr_ovf_at_5", {31'h0, bus.scr_ovf_o}, 32'd1);
    chk("scr_valid",    {31'h0, bus.scr_valid_o}, 32'd1);
    chk("scr_head_addr", {19'h0, bus.scr_addr_o}, 32'h0000);
    chk("scr_head_data", {16'h0, bus.scr_data_o}, 32'hA000);
    for (int i = 0; i < 5; i++)
      rd("scr_shadow", 15'h4000 + 15'(i), 16'hA000 + 16'(i));

    // Reset so the full+pop case starts with a clean overflow flag
    rst = 1'b1; #2 rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) wr(15'h4000 + 15'(i), 16'hA000 + 16'(i));
    chk("scr_full_no_ovf", {31'h0, bus.scr_ovf_o}, 32'd0);
    bus.scr_ready_i = 1'b1;
    wr(15'h4010, 16'hB010);
    bus.scr_ready_i = 1'b0;
    chk("scr_push_pop_ovf", {31'h0, bus.scr_ovf_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [12:0] ea;
      logic [15:0] ed;
      ea = (i < 3) ? 13'(i + 1) : 13'h0010;
      ed = (i < 3) ? 16'hA000 + 16'(i + 1) : 16'hB010;
      chk("drain_valid", {31'h0, bus.scr_valid_o}, 32'd1);
      chk("drain_addr",  {19'h0, bus.scr_addr_o}, {19'h0, ea});
      chk("drain_data",  {16'h0, bus.scr_data_o}, {16'h0, ed});
      bus.scr_ready_i = 1'b1;
      tick();
      bus.scr_ready_i = 1'b0;
    end
    chk("drain_empty", {31'h0, bus.scr_valid_o}, 32'd0);

    // Keyboard queue and CPU pops
    bus.kbd_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.kbd_code_i = 16'h0041 + 16'(i);
      tick();
    end
    bus.kbd_valid_i = 1'b0;
    chk("kbd_count3", {28'h0, bus.kbd_count_o}, 32'd3);
    rd("kbd_41", 15'h6000, 16'h0041);
    wr(15'h6000, 16'hFFFF);
    rd("kbd_42", 15'h6000, 16'h0042);
    wr(15'h6000, 16'h0000);
    rd("kbd_43", 15'h6000, 16'h0043);
    wr(15'h6000, 16'h5555);
    rd("kbd_empty", 15'h6000, 16'h0000);
    wr(15'h6000, 16'h1111);
    rd("kbd_underflow", 15'h6000, 16'h0000);
    chk("kbd_count0", {28'h0, bus.kbd_count_o}, 32'd0);

    // Fill to depth, ninth code blocked until a CPU pop frees a slot
    bus.kbd_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.kbd_code_i = 16'h0061 + 16'(i);
      tick();
    end
    bus.kbd_code_i = 16'h0069;
    chk("kbd_full_count", {28'h0, bus.kbd_count_o}, 32'd8);
    chk("kbd_full_ready", {31'h0, bus.kbd_ready_o}, 32'd0);
    tick();
    chk("kbd_9th_blocked", {28'h0, bus.kbd_count_o}, 32'd8);
    wr(15'h6000, 16'h0000);
    chk("kbd_pop_ready", {31'h0, bus.kbd_ready_o}, 32'd1);
    chk("kbd_pop_count", {28'h0, bus.kbd_count_o}, 32'd7);
    tick();
    bus.kbd_valid_i = 1'b0;
    chk("kbd_9th_taken", {28'h0, bus.kbd_count_o}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd("kbd_drain", 15'h6000, 16'h0062 + 16'(i));
      wr(15'h6000, 16'h0000);
    end
    rd("kbd_drained", 15'h6000, 16'h0000);

    // Async reset between edges with both queues occupied
    bus.kbd_valid_i = 1'b1;
    bus.kbd_code_i  = 16'h0077;
    wr(15'h4020, 16'hC0DE);
    bus.kbd_valid_i = 1'b0;
    chk("pre_rst_scr_valid", {31'h0, bus.scr_valid_o}, 32'd1);
    chk("pre_rst_kbd_count", {28'h0, bus.kbd_count_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_scr_valid", {31'h0, bus.scr_valid_o}, 32'd0);
    chk("async_kbd_count", {28'h0, bus.kbd_count_o}, 32'd0);
    chk("async_kbd_ready", {31'h0, bus.kbd_ready_o}, 32'd1);
    rd("async_kbd_read", 15'h6000, 16'h0000);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
